multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multicycle control unit for the MIPS CPU: a Moore state machine that sequences the shared datapath (one memory for instructions and data, one ALU, register file, PC) through fetch, decode, execute, memory and write-back steps. Opcode and funct come from the datapath instruction register; the block drives every enable and select in the datapath and embeds the ALU function decode. It also keeps a retired-instruction counter and a sticky illegal-instruction trap.

## Interface
- COUNT_WIDTH, 32, width of the retired-instruction counter

- clock  in  1  system clock, all state updates on posedge
- reset  in  1  synchronous, active-low; sampled on posedge clock
- run  in  1  level; 1 allows the FSM to leave IDLE and to start the next instruction
- opcode  in  6  instruction[31:26] from the instruction register
- funct  in  6  instruction[5:0] from the instruction register
- zero  in  1  ALU zero flag
- mem_ren  out  1  memory read enable
- mem_wen  out  1  memory write enable
- iord  out  1  memory address select: 0 = PC, 1 = ALU result register
- ir_write  out  1  instruction register load
- reg_write  out  1  register file write enable
- reg_dst  out  1  write address select: 0 = rt, 1 = rd
- mem_to_reg  out  1  write data select: 0 = ALU result register, 1 = memory data register
- alu_src_a  out  1  0 = PC, 1 = register A
- alu_src_b  out  2  00 = register B, 01 = constant 4, 10 = sign-extended imm, 11 = sign-extended imm << 2
- alu_control  out  4  ALU op code (0 and, 1 or, 2 add, 6 sub, 7 slt, 12 nor)
- pc_src  out  2  00 = ALU out, 01 = ALU result register, 10 = jump target
- pc_en  out  1  PC load enable = pc_write | (branch & zero)
- illegal  out  1  1 while in TRAP
- state  out  4  current state code, for debug
- instr_count  out  COUNT_WIDTH  retired-instruction count

## Operation
- State codes: IDLE 0, FETCH 1, DECODE 2, MEMADR 3, MEMREAD 4, MEMWB 5, MEMWRITE 6, EXECUTE 7, ALUWB 8, BRANCH 9, ADDIEX 10, ADDIWB 11, JUMP 12, TRAP 13. Codes 14-15 are unreachable and go to IDLE.
- Outputs are pure functions of state, except that alu_control in EXECUTE depends on funct and pc_en depends on zero. Any output not listed for a state is 0.
  - IDLE: all 0.
  - FETCH: mem_ren, ir_write, pc_write; alu_src_b 01; add.
  - DECODE: alu_src_b 11; add (branch target).
  - MEMADR / ADDIEX: alu_src_a 1; alu_src_b 10; add.
  - MEMREAD: mem_ren, iord.
  - MEMWRITE: mem_wen, iord.
  - MEMWB: reg_write, mem_to_reg.
  - EXECUTE: alu_src_a 1; alu_src_b 00; alu_control from funct: 32→2, 34→6, 36→0, 37→1, 39→12, 42→7.
  - ALUWB: reg_write, reg_dst.
  - ADDIWB: reg_write.
  - BRANCH: alu_src_a 1; sub; branch; pc_src 01.
  - JUMP: pc_write; pc_src 10.
  - TRAP: illegal only.
- Transitions:
  - IDLE→FETCH when run=1. FETCH→DECODE unconditionally.
  - DECODE dispatches on opcode:
    - 0 with a supported funct → EXECUTE; 0 with any other funct → TRAP.
    - 35 (lw) or 43 (sw) → MEMADR.
    - 4 (beq) → BRANCH.
    - 8 (addi) → ADDIEX.
    - 2 (j) → JUMP.
    - anything else → TRAP.
  - MEMADR→MEMREAD (lw) or MEMWRITE (sw); MEMREAD→MEMWB; EXECUTE→ALUWB; ADDIEX→ADDIWB.
  - Final states MEMWB, MEMWRITE, ALUWB, ADDIWB, BRANCH, JUMP → FETCH if run=1, else IDLE.
  - TRAP holds until reset.
- mem_ren and mem_wen are never both 1 in any state.
- instr_count increments by 1 on every clock edge that leaves a final state. It wraps from 2^COUNT_WIDTH-1 to 0. It does not increment for trapped instructions.

## Timing
- reset=0 at a posedge: next state is IDLE and instr_count is 0. All outputs become 0 and state reads 0, independent of the current state. This includes reset mid-instruction; a pending write must not occur after the reset edge.
- Cycles per instruction, FETCH through final state inclusive: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
- Back-to-back with run=1: the next FETCH immediately follows the final state, with no idle cycle.
- run dropping mid-instruction does not abort it; run is only sampled in IDLE and in final states.
- opcode and funct must be stable from DECODE until the final state; the instruction register loads only in FETCH.

## Test plan
- Reset then run=1 with opcode 35: state sequence 1,2,3,4,5,1. mem_ren=1 in FETCH and MEMREAD; reg_write=1 and mem_to_reg=1 only in MEMWB; instr_count=1 after MEMWB.
- R-type, funct 34 then funct 39: alu_control is 6, then 12, in EXECUTE. ALUWB asserts reg_write=1 and reg_dst=1. Funct 0 leads to TRAP with illegal=1 held for 20 cycles.
- beq in BRANCH: zero=1 gives pc_en=1 with pc_src=01; zero=0 gives pc_en=0. Both take 3 cycles and count retires.
- sw followed by j with run=1: states 1,2,3,6,1,2,12,1. mem_wen=1 only in MEMWRITE, never with mem_ren. instr_count=2.
- Reset asserted during MEMWB: next cycle state=0, all outputs 0, instr_count=0. run=0 at the end of an instruction leads to IDLE, which holds until run=1.
- Preload instr_count to all ones (COUNT_WIDTH=4 build) and retire one instruction: count reads 0.

Source files
------------

// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle MIPS control unit and its datapath.
// Ports: run/opcode/funct/zero flow into the controller; enables, selects,
//        alu_control, pc_en, illegal, state and instr_count flow out of it.
interface multicycle_control_if #(
  parameter int COUNT_WIDTH = 32
);
  logic                   run;
  logic [5:0]             opcode;
  logic [5:0]             funct;
  logic                   zero;
  logic                   mem_ren;
  logic                   mem_wen;
  logic                   iord;
  logic                   ir_write;
  logic                   reg_write;
  logic                   reg_dst;
  logic                   mem_to_reg;
  logic                   alu_src_a;
  logic [1:0]             alu_src_b;
  logic [3:0]             alu_control;
  logic [1:0]             pc_src;
  logic                   pc_en;
  logic                   illegal;
  logic [3:0]             state;
  logic [COUNT_WIDTH-1:0] instr_count;

  // Controller side.
  modport master (
    input  run, opcode, funct, zero,
    output mem_ren, mem_wen, iord, ir_write, reg_write, reg_dst, mem_to_reg,
           alu_src_a, alu_src_b, alu_control, pc_src, pc_en, illegal,
           state, instr_count
  );

  // Datapath side.
  modport slave (
    output run, opcode, funct, zero,
    input  mem_ren, mem_wen, iord, ir_write, reg_write, reg_dst, mem_to_reg,
           alu_src_a, alu_src_b, alu_control, pc_src, pc_en, illegal,
           state, instr_count
  );
endinterface

// File: rtl/multicycle_control.sv
// Moore FSM sequencing a shared-memory multicycle MIPS datapath, with ALU
// function decode, a retired-instruction counter and a sticky illegal trap.
// Ports: clock, reset (sync active-low), bus (multicycle_control_if.master).
module multicycle_control #(
  parameter int COUNT_WIDTH = 32
) (
  input logic                  clock,
  input logic                  reset,
  multicycle_control_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMREAD  = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWRITE = 4'd6,
    S_EXECUTE  = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_ADDIEX   = 4'd10,
    S_ADDIWB   = 4'd11,
    S_JUMP     = 4'd12,
    S_TRAP     = 4'd13
  } state_t;

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;
  localparam logic [3:0] ALU_NOR = 4'd12;

  state_t                 state_q;
  state_t                 state_d;
  logic [COUNT_WIDTH-1:0] count_q;
  logic                   pc_write;
  logic                   branch;
  logic                   is_final;
  logic                   funct_ok;
  logic [3:0]             funct_alu;

  // R-type funct decode; funct_ok gates dispatch so EXECUTE only ever sees
  // a function the ALU supports.
  always_comb begin
    funct_ok  = 1'b1;
    funct_alu = ALU_AND;
    case (bus.funct)
      6'd32:   funct_alu = ALU_ADD;
      6'd34:   funct_alu = ALU_SUB;
      6'd36:   funct_alu = ALU_AND;
      6'd37:   funct_alu = ALU_OR;
      6'd39:   funct_alu = ALU_NOR;
      6'd42:   funct_alu = ALU_SLT;
      default: funct_ok  = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Final states are the only ones that retire an instruction.
  always_comb begin
    case (state_q)
      S_MEMWB, S_MEMWRITE, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: is_final = 1'b1;
      default:                                                  is_final = 1'b0;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE:   state_d = bus.run ? S_FETCH : S_IDLE;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (bus.opcode)
          6'd0:        state_d = funct_ok ? S_EXECUTE : S_TRAP;
          6'd35, 6'd43: state_d = S_MEMADR;
          6'd4:        state_d = S_BRANCH;
          6'd8:        state_d = S_ADDIEX;
          6'd2:        state_d = S_JUMP;
          default:     state_d = S_TRAP;
        endcase
      end
      S_MEMADR:  state_d = (bus.opcode == 6'd35) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD: state_d = S_MEMWB;
      S_EXECUTE: state_d = S_ALUWB;
      S_ADDIEX:  state_d = S_ADDIWB;
      S_MEMWB, S_MEMWRITE, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP:
                 state_d = bus.run ? S_FETCH : S_IDLE;
      S_TRAP:    state_d = S_TRAP;
      default:   state_d = S_IDLE;
    endcase
  end

  // Output logic: Moore outputs, plus funct into alu_control and zero into pc_en.
  always_comb begin
    bus.mem_ren     = 1'b0;
    bus.mem_wen     = 1'b0;
    bus.iord        = 1'b0;
    bus.ir_write    = 1'b0;
    bus.reg_write   = 1'b0;
    bus.reg_dst     = 1'b0;
    bus.mem_to_reg  = 1'b0;
    bus.alu_src_a   = 1'b0;
    bus.alu_src_b   = 2'b00;
    bus.alu_control = ALU_AND;
    bus.pc_src      = 2'b00;
    bus.illegal     = 1'b0;
    pc_write        = 1'b0;
    branch          = 1'b0;
    case (state_q)
      S_FETCH: begin
        bus.mem_ren     = 1'b1;
        bus.ir_write    = 1'b1;
        pc_write        = 1'b1;
        bus.alu_src_b   = 2'b01;
        bus.alu_control = ALU_ADD;
      end
      S_DECODE: begin
        bus.alu_src_b   = 2'b11;
        bus.alu_control = ALU_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        bus.alu_src_a   = 1'b1;
        bus.alu_src_b   = 2'b10;
        bus.alu_control = ALU_ADD;
      end
      S_MEMREAD: begin
        bus.mem_ren = 1'b1;
        bus.iord    = 1'b1;
      end
      S_MEMWRITE: begin
        bus.mem_wen = 1'b1;
        bus.iord    = 1'b1;
      end
      S_MEMWB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
      end
      S_EXECUTE: begin
        bus.alu_src_a   = 1'b1;
        bus.alu_control = funct_alu;
      end
      S_ALUWB: begin
        bus.reg_write = 1'b1;
        bus.reg_dst   = 1'b1;
      end
      S_ADDIWB: bus.reg_write = 1'b1;
      S_BRANCH: begin
        bus.alu_src_a   = 1'b1;
        bus.alu_control = ALU_SUB;
        branch          = 1'b1;
        bus.pc_src      = 2'b01;
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        bus.pc_src = 2'b10;
      end
      S_TRAP:  bus.illegal = 1'b1;
      default: ;
    endcase
  end

  assign bus.pc_en = pc_write | (branch & bus.zero);
  assign bus.state = state_q;

  // Retired-instruction counter; a final state always leaves on the next edge.
  always_ff @(posedge clock) begin
    if (!reset)        count_q <= '0;
    else if (is_final) count_q <= count_q + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
  end

  assign bus.instr_count = count_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control (COUNT_WIDTH=4 build): state
// sequences and full control vectors per state, retire counting and wrap,
// run gating, reset mid-instruction and the sticky trap.
module tb_multicycle_control;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  multicycle_control_if #(.COUNT_WIDTH(4)) bus ();

  multicycle_control #(.COUNT_WIDTH(4)) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control vector order:
  // {mem_ren, mem_wen, iord, ir_write, reg_write, reg_dst, mem_to_reg,
  //  alu_src_a, alu_src_b[1:0], alu_control[3:0], pc_src[1:0], pc_en, illegal}
  localparam logic [17:0] V_IDLE   = 18'b0000_0000_00_0000_00_0_0;
  localparam logic [17:0] V_FETCH  = 18'b1001_0000_01_0010_00_1_0;
  localparam logic [17:0] V_DEC    = 18'b0000_0000_11_0010_00_0_0;
  localparam logic [17:0] V_ADR    = 18'b0000_0001_10_0010_00_0_0;
  localparam logic [17:0] V_MRD    = 18'b1010_0000_00_0000_00_0_0;
  localparam logic [17:0] V_MWR    = 18'b0110_0000_00_0000_00_0_0;
  localparam logic [17:0] V_MWB    = 18'b0000_1010_00_0000_00_0_0;
  localparam logic [17:0] V_EX_SUB = 18'b0000_0001_00_0110_00_0_0;
  localparam logic [17:0] V_EX_NOR = 18'b0000_0001_00_1100_00_0_0;
  localparam logic [17:0] V_ALUWB  = 18'b0000_1100_00_0000_00_0_0;
  localparam logic [17:0] V_ADDIWB = 18'b0000_1000_00_0000_00_0_0;
  localparam logic [17:0] V_BR_T   = 18'b0000_0001_00_0110_01_1_0;
  localparam logic [17:0] V_BR_N   = 18'b0000_0001_00_0110_01_0_0;
  localparam logic [17:0] V_JUMP   = 18'b0000_0000_00_0000_10_1_0;
  localparam logic [17:0] V_TRAP   = 18'b0000_0000_00_0000_00_0_1;

  function automatic logic [17:0] ctl_vec();
    return {bus.mem_ren, bus.mem_wen, bus.iord, bus.ir_write, bus.reg_write,
            bus.reg_dst, bus.mem_to_reg, bus.alu_src_a, bus.alu_src_b,
            bus.alu_control, bus.pc_src, bus.pc_en, bus.illegal};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock, then sample state and all controls away from the edge.
  task automatic step(input string tag, input logic [3:0] st, input logic [17:0] vec);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_state"}, {28'd0, bus.state}, {28'd0, st});
    check({tag, "_ctl"}, {14'd0, ctl_vec()}, {14'd0, vec});
    check({tag, "_excl"}, {31'd0, bus.mem_ren & bus.mem_wen}, 32'd0);
  endtask

  task automatic check_count(input string tag, input logic [3:0] exp);
    check(tag, {28'd0, bus.instr_count}, {28'd0, exp});
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    bus.run    = 1'b0;
    bus.opcode = 6'd0;
    bus.funct  = 6'd0;
    bus.zero   = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_state", {28'd0, bus.state}, 32'd0);
    check("rst_ctl", {14'd0, ctl_vec()}, 32'd0);
    check_count("rst_count", 4'd0);
    rst_n = 1'b1;
    step("idle_hold", 4'd0, V_IDLE);

    // lw: 1,2,3,4,5,1
    bus.opcode = 6'd35;
    bus.run    = 1'b1;
    step("lw_f", 4'd1, V_FETCH);
    step("lw_d", 4'd2, V_DEC);
    step("lw_a", 4'd3, V_ADR);
    step("lw_r", 4'd4, V_MRD);
    step("lw_wb", 4'd5, V_MWB);
    check_count("lw_cnt_pre", 4'd0);
    step("lw_nf", 4'd1, V_FETCH);
    check_count("lw_cnt", 4'd1);

    // R-type sub then nor.
    bus.opcode = 6'd0;
    bus.funct  = 6'd34;
    step("sub_d", 4'd2, V_DEC);
    step("sub_ex", 4'd7, V_EX_SUB);
    step("sub_wb", 4'd8, V_ALUWB);
    step("sub_nf", 4'd1, V_FETCH);
    check_count("sub_cnt", 4'd2);
    bus.funct = 6'd39;
    step("nor_d", 4'd2, V_DEC);
    step("nor_ex", 4'd7, V_EX_NOR);
    step("nor_wb", 4'd8, V_ALUWB);
    step("nor_nf", 4'd1, V_FETCH);
    check_count("nor_cnt", 4'd3);

    // beq taken / not taken.
    bus.opcode = 6'd4;
    bus.zero   = 1'b1;
    step("beqt_d", 4'd2, V_DEC);
    step("beqt_br", 4'd9, V_BR_T);
    step("beqt_nf", 4'd1, V_FETCH);
    check_count("beqt_cnt", 4'd4);
    bus.zero = 1'b0;
    step("beqn_d", 4'd2, V_DEC);
    step("beqn_br", 4'd9, V_BR_N);
    step("beqn_nf", 4'd1, V_FETCH);
    check_count("beqn_cnt", 4'd5);

    // sw then j: 2,3,6,1,2,12,1
    bus.opcode = 6'd43;
    step("sw_d", 4'd2, V_DEC);
    step("sw_a", 4'd3, V_ADR);
    step("sw_w", 4'd6, V_MWR);
    step("sw_nf", 4'd1, V_FETCH);
    bus.opcode = 6'd2;
    step("j_d", 4'd2, V_DEC);
    step("j_j", 4'd12, V_JUMP);
    step("j_nf", 4'd1, V_FETCH);
    check_count("swj_cnt", 4'd7);

    // addi.
    bus.opcode = 6'd8;
    step("addi_d", 4'd2, V_DEC);
    step("addi_ex", 4'd10, V_ADR);
    step("addi_wb", 4'd11, V_ADDIWB);
    step("addi_nf", 4'd1, V_FETCH);
    check_count("addi_cnt", 4'd8);

    // run drops mid-lw: instruction completes, then IDLE holds.
    bus.opcode = 6'd35;
    step("lwr_d", 4'd2, V_DEC);
    step("lwr_a", 4'd3, V_ADR);
    bus.run = 1'b0;
    step("lwr_r", 4'd4, V_MRD);
    step("lwr_wb", 4'd5, V_MWB);
    step("lwr_idle", 4'd0, V_IDLE);
    check_count("lwr_cnt", 4'd9);
    for (int i = 0; i < 3; i++) step("idle_wait", 4'd0, V_IDLE);
    bus.run = 1'b1;
    step("resume_f", 4'd1, V_FETCH);
    check_count("resume_cnt", 4'd9);

    // Reset asserted during MEMWB.
    step("rmid_d", 4'd2, V_DEC);
    step("rmid_a", 4'd3, V_ADR);
    step("rmid_r", 4'd4, V_MRD);
    step("rmid_wb", 4'd5, V_MWB);
    rst_n = 1'b0;
    step("rmid_rst", 4'd0, V_IDLE);
    check_count("rmid_cnt", 4'd0);
    rst_n   = 1'b1;
    bus.run = 1'b0;
    step("rmid_idle", 4'd0, V_IDLE);

    // Counter wrap: 15 jumps reach 4'hF, the 16th wraps to 0.
    bus.opcode = 6'd2;
    bus.run    = 1'b1;
    step("wrap_f0", 4'd1, V_FETCH);
    for (int i = 0; i < 15; i++) begin
      step("wrap_d", 4'd2, V_DEC);
      step("wrap_j", 4'd12, V_JUMP);
      step("wrap_f", 4'd1, V_FETCH);
    end
    check_count("wrap_max", 4'd15);
    step("wrap_d16", 4'd2, V_DEC);
    step("wrap_j16", 4'd12, V_JUMP);
    step("wrap_f16", 4'd1, V_FETCH);
    check_count("wrap_zero", 4'd0);

    // Unsupported funct traps and holds for 20 cycles; no retire.
    bus.opcode = 6'd0;
    bus.funct  = 6'd0;
    step("trapf_d", 4'd2, V_DEC);
    step("trapf_t", 4'd13, V_TRAP);
    for (int i = 0; i < 20; i++) step("trapf_hold", 4'd13, V_TRAP);
    check_count("trapf_cnt", 4'd0);

    // Reset clears the trap; unknown opcode also traps.
    rst_n = 1'b0;
    step("trapo_rst", 4'd0, V_IDLE);
    rst_n = 1'b1;
    step("trapo_f", 4'd1, V_FETCH);
    bus.opcode = 6'd63;
    step("trapo_d", 4'd2, V_DEC);
    step("trapo_t", 4'd13, V_TRAP);
    step("trapo_hold", 4'd13, V_TRAP);
    check_count("trapo_cnt", 4'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
